// File: rtl/boc_prn_corr.sv
// boc_prn_corr: despreads I/Q samples against the local BOC/PRN chip stream and
// produces early/prompt/late I/Q integrate-and-dump results once per code period.
//
// Ports:
//   rx_clk, rx_rst (sync, active-low)
//   rx_corr_paral[1] enable, [0] BOC wipe-off
//   rx_sample_vld qualifies rx_sample_i/q, rx_loc_boc/prn, rx_prn_sop/eop
//   tx_corr_{ie,qe,ip,qp,il,ql} dump outputs
//   tx_dump_vld 1-cycle dump strobe
//   tx_sop_err sticky sop-mid-period flag
module boc_prn_corr #(
  parameter int SAMP_WIDTH = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int SPACING    = 2
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [1:0]            rx_corr_paral,
  input  logic                  rx_sample_vld,
  input  logic [SAMP_WIDTH-1:0] rx_sample_i,
  input  logic [SAMP_WIDTH-1:0] rx_sample_q,
  input  logic                  rx_loc_boc,
  input  logic                  rx_loc_prn,
  input  logic                  rx_prn_sop,
  input  logic                  rx_prn_eop,
  output logic [ACC_WIDTH-1:0]  tx_corr_ie,
  output logic [ACC_WIDTH-1:0]  tx_corr_qe,
  output logic [ACC_WIDTH-1:0]  tx_corr_ip,
  output logic [ACC_WIDTH-1:0]  tx_corr_qp,
  output logic [ACC_WIDTH-1:0]  tx_corr_il,
  output logic [ACC_WIDTH-1:0]  tx_corr_ql,
  output logic                  tx_dump_vld,
  output logic                  tx_sop_err
);

  localparam int DL = 2 * SPACING;

  localparam logic IDLE  = 1'b0;
  localparam logic ACCUM = 1'b1;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                 state;
  logic [DL-1:0]        dl;
  logic                 chip;
  logic [2:0]           tap;
  logic [ACC_WIDTH-1:0] si_ext;
  logic [ACC_WIDTH-1:0] sq_ext;
  logic [ACC_WIDTH-1:0] acc_i  [3];
  logic [ACC_WIDTH-1:0] acc_q  [3];
  logic [ACC_WIDTH-1:0] nxt_i  [3];
  logic [ACC_WIDTH-1:0] nxt_q  [3];
  logic [ACC_WIDTH-1:0] dump_i [3];
  logic [ACC_WIDTH-1:0] dump_q [3];
  logic                 en;
  logic                 load;
  logic                 take;

  function automatic logic [ACC_WIDTH-1:0] sat_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // Top two bits disagree only on overflow; the sign bit picks the rail.
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign chip = rx_corr_paral[0] ? (rx_loc_boc ^ rx_loc_prn)
                                 : rx_loc_prn;
  // Index 0 early, 1 prompt, 2 late.
  assign tap  = {dl[DL-1], dl[SPACING-1], chip};
  assign en   = rx_corr_paral[1];
  assign load = rx_prn_sop;
  // A sample joins a period when it opens one or falls inside one.
  assign take = en && rx_sample_vld && (rx_prn_sop || state == ACCUM);

  always_comb begin
    si_ext = {{(ACC_WIDTH-SAMP_WIDTH){rx_sample_i[SAMP_WIDTH-1]}},
              rx_sample_i};
    sq_ext = {{(ACC_WIDTH-SAMP_WIDTH){rx_sample_q[SAMP_WIDTH-1]}},
              rx_sample_q};
    for (int k = 0; k < 3; k++) begin
      nxt_i[k] = tap[k] ? -si_ext : si_ext;
      nxt_q[k] = tap[k] ? -sq_ext : sq_ext;
      if (!load) begin
        nxt_i[k] = sat_add(acc_i[k], nxt_i[k]);
        nxt_q[k] = sat_add(acc_q[k], nxt_q[k]);
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      state       <= IDLE;
      dl          <= '0;
      tx_dump_vld <= 1'b0;
      tx_sop_err  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        acc_i[k]  <= '0;
        acc_q[k]  <= '0;
        dump_i[k] <= '0;
        dump_q[k] <= '0;
      end
    end else begin
      tx_dump_vld <= 1'b0;
      if (rx_sample_vld)
        dl <= {dl[DL-2:0], chip};
      if (!en) begin
        state <= IDLE;
        for (int k = 0; k < 3; k++) begin
          acc_i[k] <= '0;
          acc_q[k] <= '0;
        end
      end else if (take) begin
        if (rx_prn_sop && state == ACCUM)
          tx_sop_err <= 1'b1;
        if (rx_prn_eop) begin
          state       <= IDLE;
          tx_dump_vld <= 1'b1;
          for (int k = 0; k < 3; k++) begin
            dump_i[k] <= nxt_i[k];
            dump_q[k] <= nxt_q[k];
          end
        end else begin
          state <= ACCUM;
          for (int k = 0; k < 3; k++) begin
            acc_i[k] <= nxt_i[k];
            acc_q[k] <= nxt_q[k];
          end
        end
      end
    end
  end

  assign tx_corr_ie = dump_i[0];
  assign tx_corr_qe = dump_q[0];
  assign tx_corr_ip = dump_i[1];
  assign tx_corr_qp = dump_q[1];
  assign tx_corr_il = dump_i[2];
  assign tx_corr_ql = dump_q[2];

endmodule

// File: tb/tb_boc_prn_corr.sv
// tb_boc_prn_corr: scoreboard bench for boc_prn_corr, default widths plus an
// 8-bit-accumulator instance sharing the same stimulus.
module tb_boc_prn_corr;

  logic       rx_clk = 1'b0;
  logic       rx_rst;
  logic [1:0] rx_corr_paral;
  logic       rx_sample_vld;
  logic [3:0] rx_sample_i;
  logic [3:0] rx_sample_q;
  logic       rx_loc_boc;
  logic       rx_loc_prn;
  logic       rx_prn_sop;
  logic       rx_prn_eop;

  logic [23:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic        a_vld, a_err;
  logic [7:0]  b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic        b_vld, b_err;

  always #5 rx_clk = ~rx_clk;

  boc_prn_corr dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .rx_corr_paral(rx_corr_paral),
    .rx_sample_vld(rx_sample_vld),
    .rx_sample_i(rx_sample_i), .rx_sample_q(rx_sample_q),
    .rx_loc_boc(rx_loc_boc), .rx_loc_prn(rx_loc_prn),
    .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop),
    .tx_corr_ie(a_ie), .tx_corr_qe(a_qe),
    .tx_corr_ip(a_ip), .tx_corr_qp(a_qp),
    .tx_corr_il(a_il), .tx_corr_ql(a_ql),
    .tx_dump_vld(a_vld), .tx_sop_err(a_err)
  );

  boc_prn_corr #(.ACC_WIDTH(8)) dut8 (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .rx_corr_paral(rx_corr_paral),
    .rx_sample_vld(rx_sample_vld),
    .rx_sample_i(rx_sample_i), .rx_sample_q(rx_sample_q),
    .rx_loc_boc(rx_loc_boc), .rx_loc_prn(rx_loc_prn),
    .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop),
    .tx_corr_ie(b_ie), .tx_corr_qe(b_qe),
    .tx_corr_ip(b_ip), .tx_corr_qp(b_qp),
    .tx_corr_il(b_il), .tx_corr_ql(b_ql),
    .tx_dump_vld(b_vld), .tx_sop_err(b_err)
  );

  typedef struct {
    string n;
    int    ie, qe, ip, qp, il, ql;
    bit    err;
  } exp_t;

  exp_t q24[$];
  exp_t q8[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string who, input exp_t e,
                     input int ie, qe, ip, qp, il, ql,
                     input bit err);
    total++;
    if (ie != e.ie || qe != e.qe || ip != e.ip || qp != e.qp ||
        il != e.il || ql != e.ql || err != e.err) begin
      bad++;
      $display("FAIL %s/%s got e=%0d/%0d p=%0d/%0d l=%0d/%0d err=%0b want e=%0d/%0d p=%0d/%0d l=%0d/%0d err=%0b",
               who, e.n, ie, qe, ip, qp, il, ql, err,
               e.ie, e.qe, e.ip, e.qp, e.il, e.ql, e.err);
    end
  endtask

  always @(negedge rx_clk) begin
    if (rx_rst && a_vld) begin
      if (q24.size() == 0) begin
        total++;
        bad++;
        $display("FAIL acc24 unexpected dump pulse");
      end else begin
        cmp("acc24", q24.pop_front(),
            int'($signed(a_ie)), int'($signed(a_qe)),
            int'($signed(a_ip)), int'($signed(a_qp)),
            int'($signed(a_il)), int'($signed(a_ql)), a_err);
      end
    end
  end

  always @(negedge rx_clk) begin
    if (rx_rst && b_vld) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL acc8 unexpected dump pulse");
      end else begin
        cmp("acc8", q8.pop_front(),
            int'($signed(b_ie)), int'($signed(b_qe)),
            int'($signed(b_ip)), int'($signed(b_qp)),
            int'($signed(b_il)), int'($signed(b_ql)), b_err);
      end
    end
  end

  task automatic push_taps(input string n,
                           input int ie, ip, il, qe, qp, ql,
                           input bit err);
    exp_t e;
    e.n = n;
    e.ie = ie; e.ip = ip; e.il = il;
    e.qe = qe; e.qp = qp; e.ql = ql;
    e.err = err;
    q24.push_back(e);
    q8.push_back(e);
  endtask

  task automatic push_flat(input string n, input int i, q,
                           input bit err);
    push_taps(n, i, i, i, q, q, q, err);
  endtask

  task automatic smp(input bit v, input int i, q,
                     input bit boc, prn, sop, eop);
    rx_sample_vld = v;
    rx_sample_i   = i[3:0];
    rx_sample_q   = q[3:0];
    rx_loc_boc    = boc;
    rx_loc_prn    = prn;
    rx_prn_sop    = sop;
    rx_prn_eop    = eop;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      smp(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic prime(input bit boc, prn);
    for (int k = 0; k < 4; k++)
      smp(1'b1, 0, 0, boc, prn, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    rx_rst        = 1'b0;
    rx_corr_paral = 2'b10;
    idle(3);
    rx_rst = 1'b1;
    idle(1);

    total++;
    if ({a_ie, a_qe, a_ip, a_qp, a_il, a_ql, a_vld, a_err} != '0) begin
      bad++;
      $display("FAIL reset24 got ip=%0d vld=%0b err=%0b want 0",
               a_ip, a_vld, a_err);
    end
    total++;
    if ({b_ie, b_qe, b_ip, b_qp, b_il, b_ql, b_vld, b_err} != '0) begin
      bad++;
      $display("FAIL reset8 got ip=%0d vld=%0b err=%0b want 0",
               b_ip, b_vld, b_err);
    end

    // PRN-only, all-zero chips, 10-sample period
    push_flat("prn10", 30, -20, 1'b0);
    for (int k = 0; k < 10; k++)
      smp(1'b1, 3, -2, 1'b0, 1'b0, k == 0, k == 9);
    idle(2);

    // BOC wipe-off: boc^prn = 1 negates every product
    rx_corr_paral = 2'b11;
    prime(1'b1, 1'b0);
    push_flat("boc", -4, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      smp(1'b1, 1, 0, 1'b1, 1'b0, k == 0, k == 3);
    idle(2);

    // Same stream with wipe-off off: chip = prn = 0
    rx_corr_paral = 2'b10;
    prime(1'b1, 1'b0);
    push_flat("prnonly", 4, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      smp(1'b1, 1, 0, 1'b1, 1'b0, k == 0, k == 3);
    idle(2);

    // Single impulse at s1, I=+1
    prime(1'b0, 1'b0);
    push_flat("impulse", 6, 0, 1'b0);
    for (int k = 0; k < 8; k++)
      smp(1'b1, 1, 0, 1'b0, k == 1, k == 0, k == 7);
    idle(2);

    // Impulse at s1 with I=k: early hits I=1, prompt I=3, late I=5
    prime(1'b0, 1'b0);
    push_taps("spacing", 26, 22, 18, -6, -6, -6, 1'b0);
    for (int k = 0; k < 8; k++)
      smp(1'b1, k, -1, 1'b0, k == 1, k == 0, k == 7);
    idle(2);

    // Saturation: 40 x (+7, -8); 8-bit accumulators clip
    e.n = "sat"; e.err = 1'b0;
    e.ie = 280; e.ip = 280; e.il = 280;
    e.qe = -320; e.qp = -320; e.ql = -320;
    q24.push_back(e);
    e.ie = 127; e.ip = 127; e.il = 127;
    e.qe = -128; e.qp = -128; e.ql = -128;
    q8.push_back(e);
    for (int k = 0; k < 40; k++)
      smp(1'b1, 7, -8, 1'b0, 1'b0, k == 0, k == 39);
    idle(2);

    // sop at s5 restarts the period and raises the sticky error
    push_flat("midsop", 10, 0, 1'b1);
    for (int k = 0; k < 10; k++)
      smp(1'b1, (k < 5) ? 1 : 2, 0, 1'b0, 1'b0,
          k == 0 || k == 5, k == 9);
    idle(2);

    // sop&eop from IDLE: single-sample period
    push_flat("single", -3, 5, 1'b1);
    smp(1'b1, -3, 5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // sop&eop from ACCUM: only that sample survives
    push_flat("sopeop", 4, -1, 1'b1);
    smp(1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    smp(1'b1, 4, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Stalls with junk on the stream inputs must be invisible
    push_flat("gaps", 10, 15, 1'b1);
    for (int k = 0; k < 5; k++) begin
      smp(1'b1, 2, 3, 1'b0, 1'b0, k == 0, k == 4);
      if (k < 4)
        smp(1'b0, 7, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    idle(2);

    // Disable mid-period: partial sums dropped, later eop ignored
    smp(1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    smp(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_corr_paral = 2'b00;
    smp(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_corr_paral = 2'b10;
    smp(1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    push_flat("reenable", 3, 0, 1'b1);
    for (int k = 0; k < 3; k++)
      smp(1'b1, 1, 0, 1'b0, 1'b0, k == 0, k == 2);
    idle(4);

    total++;
    if (q24.size() != 0 || q8.size() != 0) begin
      bad++;
      $display("FAIL missing dumps got pending=%0d/%0d want 0/0",
               q24.size(), q8.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
